friscv_axi_ram_slave: RTL and testbench

// - AXI4 single-beat memory responder: target end of the processing unit's data bus.
// - Serves AW/W/AR requests from an internal word RAM.
// - Returns B/R responses in order, echoing the request ID.
// - Used as on-chip data RAM in tiles and as the bus target in unit-level benches.

---
 rtl/friscv_h.sv | 12 +
 rtl/friscv_scfifo.sv | 57 +++++
 rtl/friscv_axi_ram_slave.sv | 204 ++++++++++++++++++++
 tb/tb_friscv_axi_ram_slave.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_h.sv
// Shared AXI response encodings for the friscv bus targets.
// Single source for OKAY/DECERR and the address-range decode helper.
package friscv_h;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    function automatic logic [1:0] axi_resp_of(input logic out_of_range);
        return out_of_range ? AXI_DECERR : AXI_OKAY;
    endfunction

endpackage

// File: rtl/friscv_scfifo.sv
// Single-clock FIFO with registered count; dout is the head entry, valid when !empty.
// No fall-through: a push into an empty FIFO is visible the next cycle; full/empty are registered state.
module friscv_scfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge aclk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/friscv_axi_ram_slave.sv
// AXI4 single-beat RAM target: B one cycle after AW/W, R two cycles after AR, in-order per channel.
// Write ready drops on B FIFO full; read ready is credit based (R FIFO + RAM stage), both from registered state.
module friscv_axi_ram_slave
    import friscv_h::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 8,
    parameter int AXI_DATA_W = 32,
    parameter int RAM_DEPTH  = 1024,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    srst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [AXI_ADDR_W-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic [3:0]              awcache,
    input  logic [AXI_ID_W-1:0]     awid,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [AXI_DATA_W-1:0]   wdata,
    input  logic [AXI_DATA_W/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [AXI_ID_W-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [AXI_ADDR_W-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic [3:0]              arcache,
    input  logic [AXI_ID_W-1:0]     arid,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [AXI_ID_W-1:0]     rid,
    output logic [1:0]              rresp,
    output logic [AXI_DATA_W-1:0]   rdata
);

    localparam int STRB_W   = AXI_DATA_W / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(RAM_DEPTH);
    localparam int CRD_W    = $clog2(RSP_DEPTH) + 1;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } b_ent_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_DATA_W-1:0] data;
    } r_ent_t;

    // Any address bit above the RAM window means the access misses the array.
    function automatic logic out_of_range(input logic [AXI_ADDR_W-1:0] addr);
        return (addr >> (ADDR_LSB + IDX_W)) != '0;
    endfunction

    logic [AXI_DATA_W-1:0] ram [RAM_DEPTH];

    logic                  rdy_en_q;
    logic                  wr_fire;
    logic                  wr_oor;
    logic [IDX_W-1:0]      wr_idx;
    logic                  ar_fire;
    logic                  rd_oor;
    logic [IDX_W-1:0]      rd_idx;
    logic                  b_empty;
    logic                  b_full;
    logic                  b_pop;
    b_ent_t                b_in;
    b_ent_t                b_out;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_pop;
    r_ent_t                r_in;
    r_ent_t                r_out;
    logic                  stage_vld_q;
    logic                  stage_oor_q;
    logic [AXI_ID_W-1:0]   stage_id_q;
    logic [AXI_DATA_W-1:0] rd_data_q;
    logic [CRD_W-1:0]      r_credit_q;
    logic                  unused_sideband;

    assign unused_sideband = ^{awprot, awcache, arprot, arcache, r_full};

    // Holds every ready low while aresetn is asserted, independent of the inputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            rdy_en_q <= 1'b0;
        else
            rdy_en_q <= 1'b1;
    end

    assign wr_idx  = awaddr[ADDR_LSB +: IDX_W];
    assign wr_oor  = out_of_range(awaddr);
    assign awready = rdy_en_q & ~srst & awvalid & wvalid & ~b_full;
    assign wready  = awready;
    assign wr_fire = awready;

    assign rd_idx  = araddr[ADDR_LSB +: IDX_W];
    assign rd_oor  = out_of_range(araddr);
    assign arready = rdy_en_q & ~srst & (r_credit_q != '0);
    assign ar_fire = arvalid & arready;

    // Nonblocking read and write of the same word give read-first behaviour.
    always_ff @(posedge aclk) begin
        if (wr_fire && !wr_oor) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i])
                    ram[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (ar_fire)
            rd_data_q <= ram[rd_idx];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stage_vld_q <= 1'b0;
            stage_oor_q <= 1'b0;
            stage_id_q  <= '0;
        end else if (srst) begin
            stage_vld_q <= 1'b0;
            stage_oor_q <= 1'b0;
            stage_id_q  <= '0;
        end else begin
            stage_vld_q <= ar_fire;
            if (ar_fire) begin
                stage_oor_q <= rd_oor;
                stage_id_q  <= arid;
            end
        end
    end

    // Credits cover both the R FIFO and the RAM stage, so a pushed read never finds the FIFO full.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_credit_q <= CRD_W'(RSP_DEPTH);
        else if (srst)
            r_credit_q <= CRD_W'(RSP_DEPTH);
        else
            r_credit_q <= r_credit_q - CRD_W'(ar_fire) + CRD_W'(r_pop);
    end

    always_comb begin
        b_in      = '0;
        b_in.id   = awid;
        b_in.resp = axi_resp_of(wr_oor);
    end

    always_comb begin
        r_in      = '0;
        r_in.id   = stage_id_q;
        r_in.resp = axi_resp_of(stage_oor_q);
        r_in.data = stage_oor_q ? '0 : rd_data_q;
    end

    friscv_scfifo #(
        .WIDTH ($bits(b_ent_t)),
        .DEPTH (RSP_DEPTH)
    ) u_b_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .push    (wr_fire),
        .din     (b_in),
        .pop     (b_pop),
        .dout    (b_out),
        .empty   (b_empty),
        .full    (b_full)
    );

    friscv_scfifo #(
        .WIDTH ($bits(r_ent_t)),
        .DEPTH (RSP_DEPTH)
    ) u_r_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .push    (stage_vld_q),
        .din     (r_in),
        .pop     (r_pop),
        .dout    (r_out),
        .empty   (r_empty),
        .full    (r_full)
    );

    assign bvalid = ~b_empty;
    assign b_pop  = bvalid & bready;
    assign bid    = bvalid ? b_out.id : '0;
    assign bresp  = bvalid ? b_out.resp : '0;

    assign rvalid = ~r_empty;
    assign r_pop  = rvalid & rready;
    assign rid    = rvalid ? r_out.id : '0;
    assign rresp  = rvalid ? r_out.resp : '0;
    assign rdata  = rvalid ? r_out.data : '0;

endmodule

// File: tb/tb_friscv_axi_ram_slave.sv
// Bench for friscv_axi_ram_slave: directed vector table, corner-case sequences and random read streams.
// Expected values come from a word-array model of the RAM and the address-window rule.
module tb_friscv_axi_ram_slave;

    localparam int          RAM_DEPTH = 1024;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_DEPTH * 4);

    logic        aclk, aresetn, srst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb, awcache, arcache;
    logic [2:0]  awprot, arprot;
    logic [7:0]  awid, arid, bid, rid;
    logic [1:0]  bresp, rresp;

    friscv_axi_ram_slave #(
        .AXI_ADDR_W (32), .AXI_ID_W (8), .AXI_DATA_W (32), .RAM_DEPTH (RAM_DEPTH), .RSP_DEPTH (4)
    ) dut (
        .aclk (aclk), .aresetn (aresetn), .srst (srst),
        .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awprot (awprot),
        .awcache (awcache), .awid (awid),
        .wvalid (wvalid), .wready (wready), .wdata (wdata), .wstrb (wstrb),
        .bvalid (bvalid), .bready (bready), .bid (bid), .bresp (bresp),
        .arvalid (arvalid), .arready (arready), .araddr (araddr), .arprot (arprot),
        .arcache (arcache), .arid (arid),
        .rvalid (rvalid), .rready (rready), .rid (rid), .rresp (rresp), .rdata (rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [7:0]  id;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [7:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] mdl [RAM_DEPTH];
    int          st_acc, hs_first, hs_last;
    logic        st_arrdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        else
            passed++;
    endtask

    // Reference: a byte-addressed window of RAM_BYTES, word = addr/4, anything beyond is DECERR.
    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return (a >= RAM_BYTES) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return (a >= RAM_BYTES) ? 32'h0 : mdl[int'(a >> 2)];
    endfunction

    task automatic mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < RAM_BYTES)
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[int'(a >> 2)][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic vec_t vw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                input logic [7:0] id, input logic [1:0] r);
        vec_t v;
        v.wr = 1'b1; v.addr = a; v.data = d; v.strb = s; v.id = id; v.exp_data = '0; v.exp_resp = r;
        return v;
    endfunction

    function automatic vec_t vr(input logic [31:0] a, input logic [7:0] id, input logic [31:0] d,
                                input logic [1:0] r);
        vec_t v;
        v.wr = 1'b0; v.addr = a; v.data = '0; v.strb = '0; v.id = id; v.exp_data = d; v.exp_resp = r;
        return v;
    endfunction

    // Issue tasks start just after a rising edge and return just after the handshake edge.
    task automatic aw_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [7:0] id, input string name);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awid = id; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        while (!awready && n < 30) begin @(negedge aclk); n++; end
        check({name, "_awrdy"}, awready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic ar_issue(input logic [31:0] a, input logic [7:0] id, input string name);
        int n = 0;
        araddr = a; arid = id; arvalid = 1'b1;
        @(negedge aclk);
        while (!arready && n < 30) begin @(negedge aclk); n++; end
        check({name, "_arrdy"}, arready, 1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    // Returns the number of falling edges until valid was seen (1 = cycle after the handshake).
    task automatic b_collect(input logic [7:0] id, input logic [1:0] r, input string name, output int lat);
        lat = 1;
        @(negedge aclk);
        while (!bvalid && lat < 30) begin @(negedge aclk); lat++; end
        check({name, "_bvld"}, bvalid, 1);
        check({name, "_bid"}, bid, id);
        check({name, "_bresp"}, bresp, r);
        @(posedge aclk); #1;
    endtask

    task automatic r_collect(input logic [7:0] id, input logic [31:0] d, input logic [1:0] r,
                             input string name, output int lat);
        lat = 1;
        @(negedge aclk);
        while (!rvalid && lat < 30) begin @(negedge aclk); lat++; end
        check({name, "_rvld"}, rvalid, 1);
        check({name, "_rid"}, rid, id);
        check({name, "_rresp"}, rresp, r);
        check({name, "_rdata"}, rdata, d);
        @(posedge aclk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [7:0] id, input logic [1:0] r, input string name);
        int lat;
        aw_issue(a, d, s, id, name);
        mdl_wr(a, d, s);
        b_collect(id, r, name, lat);
        check({name, "_blat"}, lat, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] id, input logic [31:0] d,
                           input logic [1:0] r, input string name);
        int lat;
        ar_issue(a, id, name);
        r_collect(id, d, r, name, lat);
        check({name, "_rlat"}, lat, 2);
    endtask

    function automatic logic [31:0] next_addr(input bit rnd, input int k);
        if (!rnd)
            return 32'h100 + 32'(k) * 4;
        if ($urandom_range(0, 5) == 0)
            return RAM_BYTES + ($urandom_range(0, 255) << 2);
        return 32'h400 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
    endfunction

    // Back-to-back ARs with arvalid held; rready held low for `stall` cycles, then 1 or random.
    task automatic ar_stream(input int n, input bit rnd, input bit rr_rnd, input int stall, input string pfx);
        rexp_t q[$];
        rexp_t e;
        int    k = 0, got = 0, cyc = 0;
        bit    ar_hs, r_hs;
        hs_first = -1; hs_last = -1; st_acc = -1; st_arrdy = 1'bx;
        araddr = next_addr(rnd, 0); arid = 8'h80; arvalid = 1'b1;
        rready = (stall > 0) ? 1'b0 : 1'b1;
        while (got < n && cyc < 600) begin
            @(negedge aclk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (r_hs) begin
                check({pfx, "_qempty"}, q.size() == 0, 0);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check({pfx, "_rid"}, rid, e.id);
                    check({pfx, "_rresp"}, rresp, e.resp);
                    check({pfx, "_rdata"}, rdata, e.data);
                end
                got++;
            end
            if (ar_hs) begin
                e.id = arid; e.resp = exp_resp(araddr); e.data = mdl_rd(araddr);
                q.push_back(e);
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
                k++;
            end
            if (cyc == stall - 1) begin st_acc = k; st_arrdy = arready; end
            @(posedge aclk); #1;
            if (ar_hs) begin
                if (k < n) begin araddr = next_addr(rnd, k); arid = 8'(8'h80 + k); end
                else arvalid = 1'b0;
            end
            rready = (cyc + 1 < stall) ? 1'b0 : (rr_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            cyc++;
        end
        arvalid = 1'b0; rready = 1'b1;
        check({pfx, "_count"}, got, n);
    endtask

    vec_t tbl [11];

    initial begin
        int lat;
        tbl[0]  = vw(32'h10,   32'hDEADBEEF, 4'hF,    8'h21, 2'b00);
        tbl[1]  = vr(32'h10,   8'h22, 32'hDEADBEEF, 2'b00);
        tbl[2]  = vw(32'h10,   32'h0000AA00, 4'b0010, 8'h23, 2'b00);
        tbl[3]  = vr(32'h10,   8'h24, 32'hDEADAAEF, 2'b00);
        tbl[4]  = vr(32'h13,   8'h25, 32'hDEADAAEF, 2'b00);
        tbl[5]  = vw(32'h0,    32'h12345678, 4'hF,    8'h26, 2'b00);
        tbl[6]  = vr(32'h1000, 8'h27, 32'h0,        2'b11);
        tbl[7]  = vw(32'h1000, 32'hFFFFFFFF, 4'hF,    8'h28, 2'b11);
        tbl[8]  = vr(32'h0,    8'h29, 32'h12345678, 2'b00);
        tbl[9]  = vw(32'hFFC,  32'h0BADF00D, 4'hF,    8'h2A, 2'b00);
        tbl[10] = vr(32'hFFC,  8'h2B, 32'h0BADF00D, 2'b00);

        for (int i = 0; i < RAM_DEPTH; i++) mdl[i] = '0;
        aresetn = 1'b0; srst = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awid = '0; arid = '0;
        awprot = '0; arprot = '0; awcache = '0; arcache = '0;
        repeat (3) @(negedge aclk);
        check("rst_ctrl", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("rst_payload", {bid, bresp, rid, rresp, rdata}, 52'h0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk); #1;

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].wr)
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].id, tbl[i].exp_resp, $sformatf("vec%0d", i));
            else
                do_read(tbl[i].addr, tbl[i].id, tbl[i].exp_data, tbl[i].exp_resp, $sformatf("vec%0d", i));
        end

        for (int k = 0; k < 8; k++)
            do_write(32'h100 + 32'(k) * 4, 32'hA0000000 + 32'(k), 4'hF, 8'(8'h30 + k), 2'b00, "pre");

        // Six ARs against a stalled R channel: four credits, then ready must stay low.
        ar_stream(6, 1'b0, 1'b0, 12, "arfull");
        check("arfull_accepted", st_acc, 4);
        check("arfull_arready", st_arrdy, 1'b0);

        ar_stream(8, 1'b0, 1'b0, 0, "thru");
        check("thru_b2b", hs_last - hs_first, 7);

        // Same-cycle write and read of word 5: the read sees the old contents.
        do_write(32'h14, 32'h0, 4'hF, 8'h41, 2'b00, "w5init");
        awaddr = 32'h14; wdata = 32'h1; wstrb = 4'hF; awid = 8'h42; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h14; arid = 8'h43; arvalid = 1'b1;
        @(negedge aclk);
        check("same_cycle_rdy", {awready, arready}, 2'b11);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        mdl_wr(32'h14, 32'h1, 4'hF);
        b_collect(8'h42, 2'b00, "same_b", lat);
        r_collect(8'h43, 32'h0, 2'b00, "same_r", lat);
        do_read(32'h14, 8'h44, 32'h1, 2'b00, "after_same");

        // Sync reset with three B and two R responses pending.
        bready = 1'b0; rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            aw_issue(32'h200 + 32'(k) * 4, 32'h11111111 * 32'(k + 1), 4'hF, 8'(8'h50 + k), "s_aw");
            mdl_wr(32'h200 + 32'(k) * 4, 32'h11111111 * 32'(k + 1), 4'hF);
        end
        ar_issue(32'h200, 8'h60, "s_ar0");
        ar_issue(32'h204, 8'h61, "s_ar1");
        repeat (3) @(negedge aclk);
        check("srst_pending", {bvalid, rvalid}, 2'b11);
        @(posedge aclk); #1 srst = 1'b1;
        @(posedge aclk); #1 srst = 1'b0;
        @(negedge aclk);
        check("srst_valids", {bvalid, rvalid}, 2'b00);
        check("srst_payload", {bid, bresp, rid, rresp, rdata}, 52'h0);
        bready = 1'b1; rready = 1'b1;
        repeat (3) @(negedge aclk);
        check("srst_no_ghost", {bvalid, rvalid}, 2'b00);
        @(posedge aclk); #1;
        do_read(32'h204, 8'h62, 32'h22222222, 2'b00, "srst_ram");

        for (int k = 0; k < 16; k++)
            do_write(32'h400 + 32'(k) * 4, $urandom, 4'hF, 8'(k), 2'b00, "rinit");
        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            a = next_addr(1'b1, k);
            do_write(a, $urandom, 4'($urandom_range(0, 15)), 8'($urandom), exp_resp(a), "rwr");
        end
        ar_stream(32, 1'b1, 1'b1, 0, "rrd");
        ar_stream(12, 1'b1, 1'b1, 5, "rrd2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
